debug_frame_streamer: RTL and testbench

//  Debug-path source feeding the MicroBlaze/MIPS debug interface. Decodes the 6-bit request select,

---
 rtl/debug_frame_streamer_if.sv | 12 +
 rtl/debug_frame_streamer.sv | 131 +++++++++++++
 tb/tb_debug_frame_streamer.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/debug_frame_streamer_if.sv
// Frame stream from the debug frame streamer to the debug interface's frame-capture logic.
interface debug_frame_streamer_if #(
  parameter int unsigned NB_FRAME = 32
);
  logic [NB_FRAME-1:0] o_frame;
  logic                o_eod;
  logic                o_busy;
  logic                o_overrun;

  modport master (output o_frame, o_eod, o_busy, o_overrun);
  modport slave  (input  o_frame, o_eod, o_busy, o_overrun);
endinterface

// File: rtl/debug_frame_streamer.sv
// Debug frame streamer: snapshots the requested register / PC / memory word / latch strip
// and streams it as N_WORDS frames, one per cycle, followed by a one-cycle end-of-data strobe.
module debug_frame_streamer #(
  parameter int unsigned NB_FRAME  = 32,
  parameter int unsigned NB_BUFFER = 96,
  parameter int unsigned N_LATCH   = 8,
  parameter int unsigned NB_SELECT = 6
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [NB_SELECT-1:0]          i_request_select,
  input  logic [NB_FRAME-1:0]           i_reg_data,
  input  logic [NB_FRAME-1:0]           i_pc,
  input  logic [NB_FRAME-1:0]           i_data_mem,
  input  logic [NB_FRAME-1:0]           i_instr_mem,
  input  logic [N_LATCH*NB_BUFFER-1:0]  i_latch_bus,
  output logic [4:0]                    o_reg_addr,
  debug_frame_streamer_if.master        stream
);

  localparam int unsigned N_WORDS   = NB_BUFFER / NB_FRAME;
  localparam int unsigned NB_CNT    = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam int unsigned NB_PAD    = NB_BUFFER - NB_FRAME;
  localparam int unsigned SEL_DMEM  = 32;
  localparam int unsigned SEL_IMEM  = 33;
  localparam int unsigned SEL_PC    = 34;
  localparam int unsigned SEL_LATCH = 36;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    EOD    = 2'd2
  } state_t;

  state_t                state;
  logic [NB_CNT-1:0]     word_cnt;
  logic [NB_BUFFER-1:0]  shift_reg;
  logic [NB_FRAME-1:0]   frame_q;
  logic                  eod_q;
  logic                  busy_q;
  logic                  overrun_q;

  logic [NB_BUFFER-1:0]  strip;
  logic                  request;

  assign o_reg_addr = i_request_select[4:0];
  assign request    = (i_request_select != {NB_SELECT{1'b1}});

  // Source decode: pick the strip addressed by the request code, single words left-justified.
  always_comb begin
    strip = '0;
    if (!i_request_select[NB_SELECT-1]) begin
      strip = {i_reg_data, {NB_PAD{1'b0}}};
    end else if (i_request_select == NB_SELECT'(SEL_DMEM)) begin
      strip = {i_data_mem, {NB_PAD{1'b0}}};
    end else if (i_request_select == NB_SELECT'(SEL_IMEM)) begin
      strip = {i_instr_mem, {NB_PAD{1'b0}}};
    end else if (i_request_select == NB_SELECT'(SEL_PC)) begin
      strip = {i_pc, {NB_PAD{1'b0}}};
    end else begin
      for (int k = 0; k < int'(N_LATCH); k++) begin
        if (i_request_select == NB_SELECT'(SEL_LATCH + k)) begin
          strip = i_latch_bus[k*NB_BUFFER +: NB_BUFFER];
        end
      end
    end
  end

  // Streaming FSM; o_frame is loaded one word ahead so every output is a plain register.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state     <= IDLE;
      word_cnt  <= '0;
      shift_reg <= '0;
      frame_q   <= '0;
      eod_q     <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          frame_q <= '0;
          eod_q   <= 1'b0;
          busy_q  <= 1'b0;
          if (request) begin
            frame_q   <= strip[NB_BUFFER-1 -: NB_FRAME];
            shift_reg <= strip << NB_FRAME;
            word_cnt  <= '0;
            busy_q    <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          if (request) begin
            overrun_q <= 1'b1;
          end
          if (word_cnt == NB_CNT'(N_WORDS - 1)) begin
            frame_q <= '0;
            eod_q   <= 1'b1;
            state   <= EOD;
          end else begin
            frame_q   <= shift_reg[NB_BUFFER-1 -: NB_FRAME];
            shift_reg <= shift_reg << NB_FRAME;
            word_cnt  <= word_cnt + NB_CNT'(1);
          end
        end
        EOD: begin
          if (request) begin
            overrun_q <= 1'b1;
          end
          frame_q <= '0;
          eod_q   <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          frame_q <= '0;
          eod_q   <= 1'b0;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign stream.o_frame   = frame_q;
  assign stream.o_eod     = eod_q;
  assign stream.o_busy    = busy_q;
  assign stream.o_overrun = overrun_q;

endmodule

// File: tb/tb_debug_frame_streamer.sv
// Directed bench for debug_frame_streamer: vector table plus overrun and mid-stream reset sequences.
module tb_debug_frame_streamer;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   sel;
  logic [31:0]  reg_data;
  logic [31:0]  pc;
  logic [31:0]  dmem;
  logic [31:0]  imem;
  logic [767:0] latch_bus;
  logic [767:0] latch_base;
  logic [4:0]   reg_addr;

  int errors = 0;
  int checks = 0;

  debug_frame_streamer_if #(.NB_FRAME(32)) stream_if ();

  debug_frame_streamer dut (
    .i_clock          (clk),
    .i_reset          (rst),
    .i_request_select (sel),
    .i_reg_data       (reg_data),
    .i_pc             (pc),
    .i_data_mem       (dmem),
    .i_instr_mem      (imem),
    .i_latch_bus      (latch_bus),
    .o_reg_addr       (reg_addr),
    .stream           (stream_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [5:0]  sel;
    logic [31:0] reg_data;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Latch group k, word j = C000_0000 | k<<8 | j, except group 1 which carries the fixed pattern.
  function automatic logic [767:0] make_latch();
    logic [767:0] b;
    b = '0;
    for (int k = 0; k < 8; k++) begin
      for (int j = 0; j < 3; j++) begin
        b[k*96 + (2-j)*32 +: 32] = 32'hC000_0000 | 32'(k*256 + j);
      end
    end
    b[96 +: 96] = 96'h1111_1111_2222_2222_3333_3333;
    return b;
  endfunction

  task automatic load_sources(input logic [31:0] rd);
    reg_data  = rd;
    pc        = 32'h0000_0040;
    dmem      = 32'h1234_5678;
    imem      = 32'h8BAD_F00D;
    latch_bus = latch_base;
  endtask

  task automatic scramble();
    reg_data  = ~reg_data;
    pc        = 32'hFFFF_0000;
    dmem      = 32'h0BAD_0BAD;
    imem      = 32'h5555_AAAA;
    latch_bus = ~latch_base;
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".frame"}, stream_if.o_frame, 32'h0);
    chk({nm, ".busy"},  32'(stream_if.o_busy), 32'h0);
    chk({nm, ".eod"},   32'(stream_if.o_eod),  32'h0);
  endtask

  // Called just after the accepting edge; checks cycles T+1..T+4, ends at the T+4 negedge.
  task automatic run_stream(input string nm, input logic [31:0] w0, input logic [31:0] w1,
                            input logic [31:0] w2);
    @(negedge clk);
    sel = 6'h3F;
    scramble();
    chk({nm, ".w0"},    stream_if.o_frame, w0);
    chk({nm, ".busy1"}, 32'(stream_if.o_busy), 32'h1);
    chk({nm, ".eod1"},  32'(stream_if.o_eod),  32'h0);
    @(negedge clk);
    chk({nm, ".w1"},    stream_if.o_frame, w1);
    chk({nm, ".eod2"},  32'(stream_if.o_eod),  32'h0);
    @(negedge clk);
    chk({nm, ".w2"},    stream_if.o_frame, w2);
    chk({nm, ".busy3"}, 32'(stream_if.o_busy), 32'h1);
    chk({nm, ".eod3"},  32'(stream_if.o_eod),  32'h0);
    @(negedge clk);
    chk({nm, ".eodf"},  stream_if.o_frame, 32'h0);
    chk({nm, ".eod"},   32'(stream_if.o_eod),  32'h1);
    chk({nm, ".busy4"}, 32'(stream_if.o_busy), 32'h1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{"reg5",      6'h05, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 32'h0};
    vecs[1]  = '{"latch1",    6'h25, 32'h0000_0001, 32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    vecs[2]  = '{"dmem",      6'h20, 32'h0000_0002, 32'h1234_5678, 32'h0, 32'h0};
    vecs[3]  = '{"imem",      6'h21, 32'h0000_0003, 32'h8BAD_F00D, 32'h0, 32'h0};
    vecs[4]  = '{"pc",        6'h22, 32'h0000_0004, 32'h0000_0040, 32'h0, 32'h0};
    vecs[5]  = '{"latch0",    6'h24, 32'h0000_0005, 32'hC000_0000, 32'hC000_0001, 32'hC000_0002};
    vecs[6]  = '{"latch7",    6'h2B, 32'h0000_0006, 32'hC000_0700, 32'hC000_0701, 32'hC000_0702};
    vecs[7]  = '{"unmap2F",   6'h2F, 32'h0000_0007, 32'h0, 32'h0, 32'h0};
    vecs[8]  = '{"reg31",     6'h1F, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'h0, 32'h0};
    vecs[9]  = '{"unmap3E",   6'h3E, 32'h0000_0009, 32'h0, 32'h0, 32'h0};
    vecs[10] = '{"unmap23",   6'h23, 32'h0000_000A, 32'h0, 32'h0, 32'h0};

    latch_base = make_latch();
    load_sources(32'h0);
    sel = 6'h3F;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk_idle("reset");
    chk("reset.overrun", 32'(stream_if.o_overrun), 32'h0);

    // Table: each vector issued the cycle after the previous EoD, so all run back-to-back.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk_idle({vecs[i].name, ".pre"});
      load_sources(vecs[i].reg_data);
      sel = vecs[i].sel;
      #1;
      chk({vecs[i].name, ".reg_addr"}, 32'(reg_addr), 32'(vecs[i].sel[4:0]));
      @(posedge clk);
      run_stream(vecs[i].name, vecs[i].w0, vecs[i].w1, vecs[i].w2);
    end
    @(negedge clk);
    chk_idle("table.post");
    chk("table.overrun", 32'(stream_if.o_overrun), 32'h0);

    // Request dropped mid-stream: PC stream unaffected, overrun sticks, dmem never streamed.
    load_sources(32'h0);
    sel = 6'h22;
    @(posedge clk);
    @(negedge clk);
    sel = 6'h3F;
    chk("ovr.w0", stream_if.o_frame, 32'h0000_0040);
    chk("ovr.pre", 32'(stream_if.o_overrun), 32'h0);
    @(negedge clk);
    sel = 6'h20;
    chk("ovr.w1", stream_if.o_frame, 32'h0);
    @(negedge clk);
    sel = 6'h3F;
    chk("ovr.w2", stream_if.o_frame, 32'h0);
    chk("ovr.flag", 32'(stream_if.o_overrun), 32'h1);
    @(negedge clk);
    chk("ovr.eod", 32'(stream_if.o_eod), 32'h1);
    @(negedge clk);
    chk_idle("ovr.after");
    chk("ovr.sticky", 32'(stream_if.o_overrun), 32'h1);
    @(negedge clk);
    chk_idle("ovr.nostream");

    // Reset mid latch stream: outputs clear at once, no EoD, next request streams normally.
    load_sources(32'h0);
    sel = 6'h25;
    @(posedge clk);
    @(negedge clk);
    sel = 6'h3F;
    chk("rst.w0", stream_if.o_frame, 32'h1111_1111);
    @(negedge clk);
    chk("rst.w1", stream_if.o_frame, 32'h2222_2222);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_idle("rst.abort");
    chk("rst.overrun", 32'(stream_if.o_overrun), 32'h0);
    reg_data = 32'hDEAD_BEEF;
    sel = 6'h05;
    @(posedge clk);
    run_stream("rst.again", 32'hDEAD_BEEF, 32'h0, 32'h0);
    @(negedge clk);
    chk_idle("rst.post");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
